gray_step_decoder: RTL and testbench
====================================

// Module: gray_step_decoder
// PURPOSE
//  Receive side of the 3-bit Gray position code (y1,y2,y3) that the Moore up/down
//  stepper drives. Synchronises the code, converts it to binary, and detects each
//  single step and its direction. Keeps a wrapping signed position count and flags
//  illegal multi-step jumps. Sits between the stepper outputs and any consumer that
//  needs position/direction.
// PARAMETERS
//  POS_W        8   width of position counter (two's complement, wraps mod 2^POS_W)
//  SYNC_STAGES  2   flip-flop stages on g_in (>=2)
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  g_in      in   3      Gray code {y1,y2,y3}; may be asynchronous to clk
//  clr_err   in   1      synchronous pulse: clear fault and re-lock
//  step      out  1      one-cycle pulse: a legal single step was decoded
//  dir       out  1      direction of last step: 1 = up (+1), 0 = down (-1)
//  pos       out  POS_W  accumulated position
//  code_bin  out  3      binary value of the current synchronised code
//  locked    out  1      1 while in TRACK
//  err       out  1      sticky illegal-jump flag
// BEHAVIOUR
//  - Reset: step=0, dir=0, pos=0, code_bin=0, locked=0, err=0. Sync chain=0. FSM=INIT.
//  - Gray->binary: b2=g2; b1=g2^g1; b0=g2^g1^g0, with g2=y1. Mapping:
//    000=0 001=1 011=2 010=3 110=4 111=5 101=6 100=7.
//  - Each cycle: cur = bin(sync(g_in)); delta = (cur - prev) mod 8, 3-bit wrap;
//    prev <= cur every cycle in all states.
//  - FSM, registered, 3 states:
//    INIT : capture prev, no step, no pos change; next cycle -> TRACK.
//    TRACK: delta 0 -> hold.
//           delta 1 -> step=1, dir=1, pos+=1.
//           delta 7 -> step=1, dir=0, pos-=1.
//           delta 2..6 -> err=1, no step, pos held, -> FAULT.
//    FAULT: step=0, pos frozen, err stays 1. clr_err=1 -> err=0, -> INIT.
//  - The 7<->0 wrap is a legal step: 7->0 is up, 0->7 is down.
//  - pos wraps silently: 2^(POS_W-1)-1 +1 -> -2^(POS_W-1). No saturation, no flag.
//  - clr_err in INIT/TRACK: no effect. clr_err in the same cycle an illegal jump
//    is detected in TRACK: the jump wins, err=1, -> FAULT.
//  - Latency: a g_in change produces step and the pos update SYNC_STAGES+1 clk
//    edges later. code_bin has the same latency as step.
//  - locked=1 only in TRACK. After reset or clr_err, the first step can be reported
//    no earlier than 2 cycles after the code is stable.
//  - Reset mid-operation: immediate async clear; the first post-reset code is taken
//    as reference, never as a step.
// STRUCTURE
//  - Shared package: FSM state localparams (INIT/TRACK/FAULT) and the gray2bin3
//    function; the stepper encoder reuses the same function.
//  - Sub-module: gray_sync — a SYNC_STAGES-deep 3-bit sync chain with async reset.
//    Everything else lives in this module.
// TESTING
//  1. Reset, g_in=000, then 001,011,010,110 each held 4 cycles
//     -> 4 step pulses, dir=1, pos=4, code_bin=4, err=0.
//  2. Start at code 000 (bin 0), apply 100 (bin 7) then 101 (bin 6)
//     -> 2 pulses, dir=0, pos=-2 (8'hFE).
//  3. Full up cycle 0..7..0: eight steps 000,001,011,010,110,111,101,100,000
//     -> 8 pulses, pos=8, and the 7->0 step is counted as up.
//  4. From bin 1 (001) jump to bin 4 (110) -> err=1, locked=0, no step, pos held.
//     Further moves: pos unchanged. Pulse clr_err -> err=0, locked=1 two cycles
//     later, next +1 move counts.
//  5. POS_W=4, pos=7, one up step -> pos=4'b1000 (-8), err=0.
//  6. Assert reset mid-count with pos=5 -> all outputs 0 at once. After release with
//     g_in unchanged -> no step pulse.

Source files
------------

// File: rtl/gray_step_decoder_pkg.sv
// Shared definitions for the 3-bit Gray position code link.
// The stepper encoder and this decoder both import this package so the
// Gray<->binary mapping is defined in exactly one place.
package gray_step_decoder_pkg;

  // Decoder tracking states.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Modulo-8 differences between consecutive binary positions.
  localparam logic [2:0] DELTA_HOLD = 3'd0;
  localparam logic [2:0] DELTA_UP   = 3'd1;
  localparam logic [2:0] DELTA_DOWN = 3'd7;

  // 3-bit reflected Gray to binary: each binary bit is the XOR of all
  // Gray bits at or above it.
  function automatic logic [2:0] gray2bin3(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray_step_decoder_sync.sv
// Multi-stage synchroniser for the Gray code bus. Gray coding guarantees
// that only one bit changes per legal step, so bitwise synchronisation
// cannot produce a code that is neither the old nor the new value.
module gray_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [W-1:0] stage_q [SYNC_STAGES];
  logic [W-1:0] stage_d [SYNC_STAGES];

  // Next value of each stage: the first samples the input, the rest shift.
  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Chain registers, cleared asynchronously so no stale code survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign d_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_step_decoder.sv
// Receive side of the stepper's 3-bit Gray position code. Synchronises the
// code, decodes single up/down steps into a wrapping signed position and
// latches a sticky fault on any multi-step jump until clr_err re-locks.
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int POS_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       g_in,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic [2:0]       code_bin,
  output logic             locked,
  output logic             err
);

  localparam int               FILL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [POS_W-1:0]  POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

  logic [2:0]        g_sync_s;
  logic [2:0]        cur_bin_s;
  logic [2:0]        delta_s;
  logic              fill_done_s;

  state_e            state_q,    state_d;
  logic [2:0]        prev_q,     prev_d;
  logic [POS_W-1:0]  pos_q,      pos_d;
  logic              dir_q,      dir_d;
  logic              step_q,     step_d;
  logic [2:0]        code_bin_q, code_bin_d;
  logic              locked_q,   locked_d;
  logic              err_q,      err_d;
  logic [FILL_W-1:0] fill_q,     fill_d;

  gray_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (3)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (g_in),
    .d_out (g_sync_s)
  );

  assign cur_bin_s   = gray2bin3(g_sync_s);
  assign delta_s     = cur_bin_s - prev_q;
  // The sync chain holds reset zeros for SYNC_STAGES edges; INIT must not
  // take its reference until a real sampled code has reached the output.
  assign fill_done_s = (fill_q == FILL_MAX);

  // Next-state, position update and output decode.
  always_comb begin
    state_d    = state_q;
    prev_d     = cur_bin_s;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    code_bin_d = cur_bin_s;
    err_d      = err_q;
    if (fill_done_s) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FILL_ONE;
    end

    case (state_q)
      ST_INIT: begin
        if (fill_done_s) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_TRACK: begin
        case (delta_s)
          DELTA_HOLD: begin
            state_d = ST_TRACK;
          end
          DELTA_UP: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + POS_ONE;
          end
          DELTA_DOWN: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - POS_ONE;
          end
          default: begin
            // Multi-step jump: a clr_err in this same cycle is ignored.
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end
        endcase
      end
      ST_FAULT: begin
        if (clr_err) begin
          err_d   = 1'b0;
          state_d = ST_INIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    locked_d = (state_d == ST_TRACK);
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      prev_q     <= 3'd0;
      pos_q      <= {POS_W{1'b0}};
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      code_bin_q <= 3'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      fill_q     <= {FILL_W{1'b0}};
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      code_bin_q <= code_bin_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      fill_q     <= fill_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign pos      = pos_q;
  assign code_bin = code_bin_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder: an 8-bit and a 4-bit position
// instance share the same stimulus.
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] g_in = 3'b000;
  logic       clr_err = 1'b0;

  logic       step8, dir8, locked8, err8;
  logic [7:0] pos8;
  logic [2:0] code8;
  logic       step4, dir4, locked4, err4;
  logic [3:0] pos4;
  logic [2:0] code4;

  int checks = 0;
  int failures = 0;
  int n8 = 0;
  int n4 = 0;
  int base8;

  gray_step_decoder #(.POS_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .g_in(g_in), .clr_err(clr_err),
    .step(step8), .dir(dir8), .pos(pos8), .code_bin(code8),
    .locked(locked8), .err(err8)
  );

  gray_step_decoder #(.POS_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset(reset), .g_in(g_in), .clr_err(clr_err),
    .step(step4), .dir(dir4), .pos(pos4), .code_bin(code4),
    .locked(locked4), .err(err4)
  );

  always #5 clk = ~clk;

  // Count step pulses away from the active edge.
  always @(negedge clk) begin
    if (step8 === 1'b1) n8 = n8 + 1;
    if (step4 === 1'b1) n4 = n4 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] code, input int n);
    g_in = code;
    tick(n);
  endtask

  task automatic do_reset(input logic [2:0] code);
    g_in = code;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    tick(1);
    checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL reset_step got=%0b exp=0", step8); end
    checks++; if (dir8 !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", dir8); end
    checks++; if (pos8 !== 8'h00) begin failures++; $display("FAIL reset_pos got=%0h exp=00", pos8); end
    checks++; if (code8 !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code8); end
    checks++; if (locked8 !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err8); end
    reset = 1'b0;
    tick(6);
    checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL reset_relock got=%0b exp=1", locked8); end
    checks++; if (n8 !== 0) begin failures++; $display("FAIL reset_nostep got=%0d exp=0", n8); end
  endtask

  task automatic test_count_up;
    base8 = n8;
    apply(3'b001, 4); apply(3'b011, 4); apply(3'b010, 4); apply(3'b110, 4);
    checks++; if (n8 - base8 !== 4) begin failures++; $display("FAIL up_pulses got=%0d exp=4", n8 - base8); end
    checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL up_dir got=%0b exp=1", dir8); end
    checks++; if (pos8 !== 8'd4) begin failures++; $display("FAIL up_pos got=%0h exp=04", pos8); end
    checks++; if (code8 !== 3'd4) begin failures++; $display("FAIL up_code got=%0d exp=4", code8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL up_err got=%0b exp=0", err8); end
  endtask

  task automatic test_latency;
    // Code 111 (bin 5) from 110: step visible after exactly 3 edges.
    base8 = n8;
    g_in = 3'b111;
    tick(2);
    checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL lat_early got=%0b exp=0", step8); end
    checks++; if (code8 !== 3'd4) begin failures++; $display("FAIL lat_code_early got=%0d exp=4", code8); end
    tick(1);
    checks++; if (step8 !== 1'b1) begin failures++; $display("FAIL lat_step got=%0b exp=1", step8); end
    checks++; if (code8 !== 3'd5) begin failures++; $display("FAIL lat_code got=%0d exp=5", code8); end
    tick(1);
    checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL lat_pulse_width got=%0b exp=0", step8); end
    checks++; if (pos8 !== 8'd5) begin failures++; $display("FAIL lat_pos got=%0h exp=05", pos8); end
  endtask

  task automatic test_count_down;
    do_reset(3'b000);
    base8 = n8;
    apply(3'b100, 4);
    checks++; if (pos8 !== 8'hFF) begin failures++; $display("FAIL down_pos1 got=%0h exp=ff", pos8); end
    apply(3'b101, 4);
    checks++; if (n8 - base8 !== 2) begin failures++; $display("FAIL down_pulses got=%0d exp=2", n8 - base8); end
    checks++; if (dir8 !== 1'b0) begin failures++; $display("FAIL down_dir got=%0b exp=0", dir8); end
    checks++; if (pos8 !== 8'hFE) begin failures++; $display("FAIL down_pos got=%0h exp=fe", pos8); end
    checks++; if (code8 !== 3'd6) begin failures++; $display("FAIL down_code got=%0d exp=6", code8); end
  endtask

  task automatic test_full_cycle_and_wrap;
    do_reset(3'b000);
    base8 = n8;
    apply(3'b001, 4); apply(3'b011, 4); apply(3'b010, 4); apply(3'b110, 4);
    apply(3'b111, 4); apply(3'b101, 4); apply(3'b100, 4);
    checks++; if (pos4 !== 4'd7) begin failures++; $display("FAIL wrap4_pre got=%0h exp=7", pos4); end
    checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL cyc_dir_pre got=%0b exp=1", dir8); end
    apply(3'b000, 4);
    checks++; if (n8 - base8 !== 8) begin failures++; $display("FAIL cyc_pulses got=%0d exp=8", n8 - base8); end
    checks++; if (pos8 !== 8'd8) begin failures++; $display("FAIL cyc_pos got=%0h exp=08", pos8); end
    checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL cyc_wrap_dir got=%0b exp=1", dir8); end
    checks++; if (pos4 !== 4'b1000) begin failures++; $display("FAIL wrap4_pos got=%0h exp=8", pos4); end
    checks++; if (err4 !== 1'b0) begin failures++; $display("FAIL wrap4_err got=%0b exp=0", err4); end
  endtask

  task automatic test_fault_recover;
    do_reset(3'b000);
    apply(3'b001, 4);
    base8 = n8;
    // clr_err while tracking does nothing.
    clr_err = 1'b1; tick(2); clr_err = 1'b0; tick(1);
    checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL clr_track_locked got=%0b exp=1", locked8); end
    apply(3'b110, 4);
    checks++; if (err8 !== 1'b1) begin failures++; $display("FAIL jump_err got=%0b exp=1", err8); end
    checks++; if (locked8 !== 1'b0) begin failures++; $display("FAIL jump_locked got=%0b exp=0", locked8); end
    checks++; if (pos8 !== 8'd1) begin failures++; $display("FAIL jump_pos got=%0h exp=01", pos8); end
    apply(3'b111, 4); apply(3'b101, 4);
    checks++; if (pos8 !== 8'd1) begin failures++; $display("FAIL fault_frozen got=%0h exp=01", pos8); end
    checks++; if (n8 - base8 !== 0) begin failures++; $display("FAIL fault_nostep got=%0d exp=0", n8 - base8); end
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL clr_err got=%0b exp=0", err8); end
    checks++; if (locked8 !== 1'b0) begin failures++; $display("FAIL clr_locked_early got=%0b exp=0", locked8); end
    tick(1);
    checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL clr_relock got=%0b exp=1", locked8); end
    apply(3'b100, 4);
    checks++; if (pos8 !== 8'd2) begin failures++; $display("FAIL relock_step_pos got=%0h exp=02", pos8); end
    checks++; if (n8 - base8 !== 1) begin failures++; $display("FAIL relock_pulses got=%0d exp=1", n8 - base8); end
    // Jump (bin 7 -> bin 3) with clr_err on the detection cycle: jump wins.
    g_in = 3'b010;
    tick(2);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    checks++; if (err8 !== 1'b1) begin failures++; $display("FAIL jump_wins_err got=%0b exp=1", err8); end
    tick(3);
    checks++; if (locked8 !== 1'b0) begin failures++; $display("FAIL jump_wins_locked got=%0b exp=0", locked8); end
  endtask

  task automatic test_reset_mid;
    do_reset(3'b000);
    apply(3'b001, 4); apply(3'b011, 4); apply(3'b010, 4); apply(3'b110, 4); apply(3'b111, 4);
    checks++; if (pos8 !== 8'd5) begin failures++; $display("FAIL mid_pre_pos got=%0h exp=05", pos8); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({step8, dir8, pos8, code8, locked8, err8} !== 14'd0) begin failures++; $display("FAIL mid_async_clear got=%0h exp=0", {step8, dir8, pos8, code8, locked8, err8}); end
    tick(2);
    reset = 1'b0;
    base8 = n8;
    tick(8);
    checks++; if (n8 - base8 !== 0) begin failures++; $display("FAIL mid_nostep got=%0d exp=0", n8 - base8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL mid_err got=%0b exp=0", err8); end
    checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL mid_pos got=%0h exp=00", pos8); end
    checks++; if (code8 !== 3'd5) begin failures++; $display("FAIL mid_code got=%0d exp=5", code8); end
    checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL mid_locked got=%0b exp=1", locked8); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_latency;
    test_count_down;
    test_full_cycle_and_wrap;
    test_fault_recover;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
